// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register/data widths, the writeback record,
// and the per-cycle writer selection.
package wb_arbiter_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_addr_t rd;
    data_t     data;
  } wb_rec_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_BUF
  } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// ALU/LSU result inputs and register-file write port of the writeback arbiter.
interface wb_arbiter_if import wb_arbiter_pkg::*; ;

  logic                alu_valid_i;
  reg_addr_t           alu_rd_i;
  data_t               alu_data_i;
  logic                lsu_valid_i;
  logic                lsu_ready_o;
  reg_addr_t           lsu_rd_i;
  data_t               lsu_data_i;
  logic                alu_stall_o;
  reg_addr_t           RDaddr_o;
  data_t               RDdata_o;
  logic                RegWrite_o;
  logic [NUM_REGS-1:0] pending_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o, alu_stall_o, RDaddr_o, RDdata_o, RegWrite_o, pending_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o, alu_stall_o, RDaddr_o, RDdata_o, RegWrite_o, pending_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Strict-FIFO buffer of LSU writeback records (DEPTH a power of two).
// With WB_SCOREBOARD_EN defined, entry contents and occupancy are exported.
module wb_fifo import wb_arbiter_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_rec_t                      wdata_i,
  output wb_rec_t                      rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef WB_SCOREBOARD_EN
  ,
  output wb_rec_t [DEPTH-1:0]          entries_o,
  output logic [DEPTH-1:0]             valid_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_rec_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

`ifdef WB_SCOREBOARD_EN
  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      entries_o[i] = mem_q[i];
      valid_o[i]   = ({1'b0, off} < count_q);
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered LSU results onto one
// register-file write port, with starvation relief. WB_SCOREBOARD_EN enables pending_o.
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_MAX+1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX-1);

  wb_rec_t       head, wdata, rec;
  logic          full, empty, push, pop;
  logic [CW-1:0] count;
  wb_sel_e       sel;

  logic          stall_q, stall_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  reg_addr_t     addr_q, addr_d;
  data_t         data_q, data_d;

  assign bus.lsu_ready_o = (count < DEPTH_C);
  assign push  = bus.lsu_valid_i && !full;
  assign wdata = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};
  assign pop   = (sel == SEL_BUF);

`ifdef WB_SCOREBOARD_EN
  wb_rec_t [DEPTH-1:0] entries;
  logic    [DEPTH-1:0] valid;
  logic [NUM_REGS-1:0] pending;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
`ifdef WB_SCOREBOARD_EN
    ,
    .entries_o (entries),
    .valid_o   (valid)
`endif
  );

  always_comb begin
    sel = SEL_NONE;
    if (stall_q) begin
      if (!empty) sel = SEL_BUF;
    end else if (bus.alu_valid_i) begin
      sel = SEL_ALU;
    end else if (!empty) begin
      sel = SEL_BUF;
    end
  end

  always_comb begin
    rec    = (sel == SEL_BUF) ? head : wb_rec_t'{rd: bus.alu_rd_i, data: bus.alu_data_i};
    we_d   = (sel != SEL_NONE) && (rec.rd != '0);
    addr_d = we_d ? rec.rd   : addr_q;
    data_d = we_d ? rec.data : data_q;
  end

  // A loss that brings the count to STARVE_MAX schedules the stall cycle; the stall
  // pops the head, which clears the count again.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (sel == SEL_ALU) begin
      starve_d = starve_q + SW'(1);
      stall_d  = (starve_q >= STARVE_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= 1'b0;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.alu_stall_o = stall_q;
  assign bus.RegWrite_o  = we_q;
  assign bus.RDaddr_o    = addr_q;
  assign bus.RDdata_o    = data_q;

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].rd != '0)) pending[entries[i].rd] = 1'b1;
    end
  end
  assign bus.pending_o = pending;
`else
  assign bus.pending_o = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, LSU result buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles a non-empty buffer may lose to the ALU.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 alu_valid_i  in  1  single-cycle ALU result present; no back-pressure except alu_stall_o.
REQ-006 alu_rd_i  in  5  ALU destination register.
REQ-007 alu_data_i  in  32  ALU result, signed.
REQ-008 lsu_valid_i  in  1 / lsu_ready_o  out  1  load/multi-cycle result handshake; transfer when both high.
REQ-009 lsu_rd_i  in  5 / lsu_data_i  in  32  load/multi-cycle destination and data.
REQ-010 alu_stall_o  out  1  registered; upstream ALU holds its result this cycle.
REQ-011 RDaddr_o  out  5 / RDdata_o  out  32 / RegWrite_o  out  1  registered register-file write port.
REQ-012 pending_o  out  32  bit n set while an LSU write to xn is buffered.

Function
REQ-013 Each cycle SHALL select at most one writer: buffer head if alu_stall_o=1, else ALU if alu_valid_i=1, else buffer head if non-empty, else none.
REQ-014 Selected result SHALL appear on RDaddr_o/RDdata_o with RegWrite_o=1 exactly one cycle later; otherwise RegWrite_o=0 and RDaddr_o/RDdata_o hold.
REQ-015 Results with rd=0 SHALL be consumed by selection but produce RegWrite_o=0 (x0 never written).
REQ-016 lsu_ready_o SHALL equal (count < DEPTH), combinational from count only; push when full is impossible.
REQ-017 LSU entry accepted at cycle T SHALL be eligible at T+1; earliest RegWrite_o at T+2.
REQ-018 Simultaneous push and pop SHALL be supported; count unchanged; read/write pointers wrap modulo DEPTH.
REQ-019 Buffer SHALL be strict FIFO; LSU results never reordered among themselves.
REQ-020 Starvation counter SHALL increment each cycle buffer non-empty and ALU selected; clear on any buffer pop or when buffer empty.
REQ-021 When counter reaches STARVE_MAX, alu_stall_o SHALL be 1 the next cycle for exactly one cycle, then counter clears.
REQ-022 alu_valid_i asserted during alu_stall_o=1 SHALL be ignored (upstream retries next cycle).
REQ-023 alu_stall_o SHALL never assert while buffer empty.
REQ-024 ALU and buffer head with the same rd SHALL still be serialized per REQ-013; ordering hazards are the core's responsibility via pending_o.

Reset
REQ-025 While rst=1: count=0, pointers=0, starvation counter=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, alu_stall_o=0, pending_o=0, lsu_ready_o=1.
REQ-026 Reset mid-operation SHALL discard all buffered entries; no write issued for them after release.

Configuration
REQ-027 Macro WB_SCOREBOARD_EN: defined -> pending_o tracks buffered rd per REQ-012 (bit set on accept, cleared on pop if no other buffered entry has same rd; x0 never set).
REQ-028 Undefined -> pending_o tied to 32'b0, no scoreboard logic.

Structure
REQ-029 Shared package SHALL hold register-address width (5), data width (32), and the writeback record type {rd, data}.
REQ-030 One sub-module wb_fifo (parameterised DEPTH, push/pop/full/empty/count) SHALL implement the buffer.

Verification
REQ-031 ALU only: alu x5=32'h1234 at T -> RegWrite_o=1, RDaddr_o=5, RDdata_o=32'h1234 at T+1; idle -> RegWrite_o=0.
REQ-032 LSU x7=32'hDEAD at T, ALU idle -> RDaddr_o=7 at T+2; pending_o[7]=1 from T+1 until pop (scoreboard build).
REQ-033 Fill: three LSU pushes with ALU busy, DEPTH=2 -> lsu_ready_o=0 after second accept; entries later written in push order.
REQ-034 Starvation: one buffered entry, ALU valid every cycle, STARVE_MAX=4 -> alu_stall_o=1 for one cycle, head written next cycle, ALU resumes.
REQ-035 rd=0 from ALU and LSU -> RegWrite_o stays 0; buffer drains normally.
REQ-036 Assert rst with two entries buffered -> lsu_ready_o=1, pending_o=0, no RegWrite_o for discarded entries after release.
